// File: rtl/note_pkg.sv
// Shared definitions for the note RAM sequencer: word geometry, end-of-song
// marker and the sequencer state encoding.
package note_pkg;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 6;
  localparam int END_FLAG_BIT = DATA_W - 1;

  localparam logic [DATA_W-1:0] END_MARK = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    P_WAIT,
    P_RD,
    P_CAP,
    R_WAIT,
    R_END
  } seq_state_e;

endpackage

// File: rtl/note_sequencer.sv
// Tempo-driven master for the note RAM: plays one word per tick into note_out,
// or records one captured note per tick, terminating a recording with an end marker.
module note_sequencer #(
  parameter int ADDR_W = note_pkg::ADDR_W,
  parameter int DATA_W = note_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              play,
  input  logic              record,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [DATA_W-2:0] rec_note,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-2:0] note_out,
  output logic              note_valid,
  output logic              playing,
  output logic              recording,
  output logic              done
);

  import note_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] END_WORD  = {1'b1, {(DATA_W-1){1'b0}}};

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-2:0] note_q, note_d;
  logic              note_valid_q, note_valid_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d      = state_q;
    addr_d       = addr_q;
    wren_d       = 1'b0;
    wdata_d      = wdata_q;
    note_d       = note_q;
    note_valid_d = 1'b0;
    done_d       = 1'b0;
    // A write just issued keeps its address for that cycle; the bump lands one cycle later.
    wr_addr      = wren_q ? addr_q + 1'b1 : addr_q;

    unique case (state_q)
      IDLE: begin
        if (play) begin
          addr_d  = '0;
          state_d = P_WAIT;
        end else if (record) begin
          addr_d  = '0;
          state_d = R_WAIT;
        end
      end

      P_WAIT: begin
        if (stop) begin
          note_d  = '0;
          state_d = IDLE;
        end else if (tick) begin
          state_d = P_RD;
        end
      end

      P_RD: begin
        if (stop) begin
          note_d  = '0;
          state_d = IDLE;
        end else begin
          state_d = P_CAP;
        end
      end

      P_CAP: begin
        if (stop) begin
          note_d  = '0;
          state_d = IDLE;
        end else if (ram_rdata[DATA_W-1]) begin
          // Restarting from a non-zero address rereads word 0 within the same tick.
          if (loop_en && (addr_q != '0)) begin
            addr_d  = '0;
            state_d = P_RD;
          end else begin
            note_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          note_d       = ram_rdata[DATA_W-2:0];
          note_valid_d = 1'b1;
          if ((addr_q == ADDR_LAST) && !loop_en) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = P_WAIT;
          end
        end
      end

      R_WAIT: begin
        addr_d = wr_addr;
        if (stop) begin
          state_d = R_END;
        end else if (tick) begin
          wren_d  = 1'b1;
          wdata_d = {1'b0, rec_note};
          if (wr_addr == ADDR_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      R_END: begin
        wren_d  = 1'b1;
        wdata_d = END_WORD;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wren_q       <= 1'b0;
      wdata_q      <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wren_q       <= wren_d;
      wdata_q      <= wdata_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      done_q       <= done_d;
    end
  end

  assign ram_addr   = addr_q;
  assign ram_wren   = wren_q;
  assign ram_wdata  = wdata_q;
  assign note_out   = note_q;
  assign note_valid = note_valid_q;
  assign done       = done_q;
  assign playing    = (state_q == P_WAIT) || (state_q == P_RD) || (state_q == P_CAP);
  assign recording  = (state_q == R_WAIT) || (state_q == R_END);

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a behavioural RAM plus a song-level
// reference model predicting each tick's note, latency and end-of-song outcome.
module tb_note_sequencer;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] END_W = {1'b1, {(DW-1){1'b0}}};

  logic          clk = 1'b0;
  logic          reset, tick, play, record, stop, loop_en;
  logic [DW-2:0] rec_note;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-2:0] note_out;
  logic          note_valid, playing, recording, done;

  note_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .play(play), .record(record),
    .stop(stop), .loop_en(loop_en), .rec_note(rec_note), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .note_out(note_out), .note_valid(note_valid), .playing(playing),
    .recording(recording), .done(done)
  );

  initial forever #5 clk = ~clk;

  // Behavioural RAM with one-cycle read latency and a bench-side load port.
  logic [DW-1:0] mem [DEPTH];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  int            wr_cnt = 0;
  int            dbl_wr = 0;
  logic          wren_prev = 1'b0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    wren_prev <= ram_wren;
    if (ram_wren) wr_cnt <= wr_cnt + 1;
    if (ram_wren && wren_prev) dbl_wr <= dbl_wr + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  // Reference model state: song image, current song position, loop mode.
  logic [DW-1:0] img [DEPTH];
  int            pos;
  bit            m_loop;
  bit            active;

  task automatic load_word(input int a, input logic [DW-1:0] d);
    img[a]  = d;
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic start_play(input string tag, input bit lp, input bit also_record);
    loop_en = lp;
    m_loop  = lp;
    play    = 1'b1;
    record  = also_record;
    step();
    play    = 1'b0;
    record  = 1'b0;
    pos     = 0;
    active  = 1'b1;
    check({tag, "_playing"}, 64'(playing), 64'(1));
    check({tag, "_not_rec"}, 64'(recording), 64'(0));
  endtask

  task automatic play_tick(input string tag, input bit do_stop, input bit with_tick);
    int lat, hit, extra, p;
    bit w_valid, w_done, ends;
    logic [DW-2:0] w_note;
    cycles(int'($urandom_range(0, 3)));
    if (do_stop) begin
      stop = 1'b1;
      tick = with_tick;
      step();
      stop = 1'b0;
      tick = 1'b0;
      check({tag, "_stop_idle"}, 64'(playing), 64'(0));
      check({tag, "_stop_note"}, 64'(note_out), 64'(0));
      hit = 0;
      for (int i = 0; i < 6; i++) begin
        if (note_valid || done) hit++;
        step();
      end
      check({tag, "_stop_quiet"}, 64'(hit), 64'(0));
      active = 1'b0;
      return;
    end
    // Predict this tick's outcome from the song image.
    lat = 3;
    p   = pos;
    if (img[p][DW-1] && m_loop && p != 0) begin
      p   = 0;
      lat = 5;
    end
    if (img[p][DW-1]) begin
      w_valid = 1'b0; w_done = 1'b1; w_note = '0; ends = 1'b1;
    end else begin
      w_valid = 1'b1;
      w_note  = img[p][DW-2:0];
      if (p == DEPTH - 1 && !m_loop) begin
        w_done = 1'b1; ends = 1'b1;
      end else begin
        w_done = 1'b0; ends = 1'b0;
        p = (p + 1) % DEPTH;
      end
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    hit = 0;
    extra = 0;
    for (int i = 1; i <= 8; i++) begin
      if (note_valid || done) begin
        if (hit == 0) begin
          hit = i;
          check({tag, "_valid"}, 64'(note_valid), 64'(w_valid));
          check({tag, "_done"}, 64'(done), 64'(w_done));
          check({tag, "_note"}, 64'(note_out), 64'(w_note));
        end else begin
          extra++;
        end
      end
      step();
    end
    check({tag, "_lat"}, 64'(hit), 64'(lat));
    check({tag, "_extra"}, 64'(extra), 64'(0));
    check({tag, "_playing_after"}, 64'(playing), 64'(!ends));
    pos    = p;
    active = !ends;
  endtask

  task automatic end_play(input string tag);
    if (active) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      check({tag, "_end_idle"}, 64'(playing), 64'(0));
      active = 1'b0;
    end
  endtask

  task automatic do_record(input string tag, input int n);
    logic [DW-2:0] notes [$];
    logic [DW-2:0] nt;
    int wr0, dbl0;
    wr0  = wr_cnt;
    dbl0 = dbl_wr;
    record = 1'b1;
    step();
    record = 1'b0;
    check({tag, "_recording"}, 64'(recording), 64'(1));
    check({tag, "_addr0"}, 64'(ram_addr), 64'(0));
    for (int k = 0; k < n; k++) begin
      nt = DW'($urandom()) >> 1;
      notes.push_back(nt);
      rec_note = nt;
      tick = 1'b1;
      step();
      tick = 1'b0;
      check($sformatf("%s_wren%0d", tag, k), 64'(ram_wren), 64'(1));
      check($sformatf("%s_waddr%0d", tag, k), 64'(ram_addr), 64'(k));
      check($sformatf("%s_wdata%0d", tag, k), 64'(ram_wdata), 64'({1'b0, nt}));
      check($sformatf("%s_done%0d", tag, k), 64'(done), 64'(k == DEPTH - 1));
      step();
      check($sformatf("%s_wren_off%0d", tag, k), 64'(ram_wren), 64'(0));
      check($sformatf("%s_rec%0d", tag, k), 64'(recording), 64'(k != DEPTH - 1));
      if (k != DEPTH - 1)
        check($sformatf("%s_next_addr%0d", tag, k), 64'(ram_addr), 64'(k + 1));
      cycles(int'($urandom_range(1, 3)));
    end
    if (n < DEPTH) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      check({tag, "_rend_rec"}, 64'(recording), 64'(1));
      check({tag, "_rend_nowr"}, 64'(ram_wren), 64'(0));
      step();
      check({tag, "_end_wren"}, 64'(ram_wren), 64'(1));
      check({tag, "_end_addr"}, 64'(ram_addr), 64'(n));
      check({tag, "_end_data"}, 64'(ram_wdata), 64'(END_W));
      check({tag, "_end_done"}, 64'(done), 64'(0));
      check({tag, "_end_idle"}, 64'(recording), 64'(0));
      step();
      check({tag, "_end_wren_off"}, 64'(ram_wren), 64'(0));
    end
    step();
    for (int k = 0; k < n; k++)
      check($sformatf("%s_mem%0d", tag, k), 64'(mem[k]), 64'({1'b0, notes[k]}));
    if (n < DEPTH) check({tag, "_mem_end"}, 64'(mem[n]), 64'(END_W));
    check({tag, "_wr_count"}, 64'(wr_cnt - wr0), 64'(n + ((n < DEPTH) ? 1 : 0)));
    check({tag, "_single_cycle_wr"}, 64'(dbl_wr - dbl0), 64'(0));
  endtask

  initial begin
    int len, nt;
    reset = 1'b1; tick = 1'b0; play = 1'b0; record = 1'b0; stop = 1'b0;
    loop_en = 1'b0; rec_note = '0;
    cycles(3);
    check("rst_addr", 64'(ram_addr), 64'(0));
    check("rst_wren", 64'(ram_wren), 64'(0));
    check("rst_wdata", 64'(ram_wdata), 64'(0));
    check("rst_note", 64'(note_out), 64'(0));
    check("rst_valid", 64'(note_valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_state", 64'({playing, recording}), 64'(0));
    reset = 1'b0;
    step();

    // Fixed song 5, 7, 9, END: one-shot then looping.
    load_word(0, 32'd5);
    load_word(1, 32'd7);
    load_word(2, 32'd9);
    load_word(3, END_W);
    start_play("song", 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) play_tick($sformatf("song_t%0d", t), 1'b0, 1'b0);
    check("song_ended", 64'(active), 64'(0));

    start_play("loop", 1'b1, 1'b0);
    record = 1'b1;
    step();
    record = 1'b0;
    check("loop_record_ignored", 64'(recording), 64'(0));
    for (int t = 0; t < 5; t++) play_tick($sformatf("loop_t%0d", t), 1'b0, 1'b0);
    check("loop_still_playing", 64'(playing), 64'(1));
    end_play("loop");

    // Short recording terminated by stop, then a full-memory recording.
    do_record("rec2", 2);
    do_record("recfull", DEPTH);

    // Empty song with looping must end at once.
    load_word(0, END_W);
    start_play("empty", 1'b1, 1'b0);
    play_tick("empty_t0", 1'b0, 1'b0);

    // Stop together with tick while waiting.
    load_word(0, 32'd11);
    load_word(1, 32'd12);
    load_word(2, END_W);
    start_play("stoptick", 1'b0, 1'b0);
    play_tick("stoptick_t0", 1'b0, 1'b0);
    play_tick("stoptick_stop", 1'b1, 1'b1);

    // Randomized songs of random length, loop mode and occasional stops.
    for (int s = 0; s < 6; s++) begin
      len = (s == 5) ? DEPTH : int'($urandom_range(1, DEPTH - 1));
      for (int i = 0; i < len; i++) load_word(i, {1'b0, 31'($urandom())});
      if (len < DEPTH) load_word(len, END_W);
      start_play($sformatf("rnd%0d", s), 1'($urandom_range(0, 1)), 1'b0);
      nt = int'($urandom_range(1, 70));
      for (int t = 0; t < nt && active; t++)
        play_tick($sformatf("rnd%0d_t%0d", s, t), $urandom_range(0, 11) == 0,
                  1'($urandom_range(0, 1)));
      end_play($sformatf("rnd%0d", s));
    end

    do_record("recrnd", int'($urandom_range(1, 12)));

    // Reset during a recording write aborts everything.
    record = 1'b1;
    step();
    record = 1'b0;
    rec_note = 31'h2A;
    tick = 1'b1;
    step();
    tick = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rrst_addr", 64'(ram_addr), 64'(0));
    check("rrst_wren", 64'(ram_wren), 64'(0));
    check("rrst_wdata", 64'(ram_wdata), 64'(0));
    check("rrst_note", 64'({note_out, note_valid, done}), 64'(0));
    check("rrst_state", 64'({playing, recording}), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
